bus_master_7501: RTL and testbench

Bus-cycle initiator for the 7501 CPU socket. It drives the socket's address, R/W and data pins from a simple host command port, so a controller (loader, debugger, memory-fill engine) can run single or burst reads and writes on the target bus without a real CPU. It complies with AEC bus release and RDY read stalls exactly as a 7501 does.

---
 rtl/bus_master_7501.sv | 116 +++++++++++
 tb/tb_bus_master_7501.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_7501.sv
// Bus-cycle initiator for the 7501 CPU socket: runs host-commanded single/burst
// reads and writes, yielding the bus on AEC low and stretching reads on RDY low.
module bus_master_7501 (
  input  logic            clock,
  input  logic            _reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_rw,
  input  logic [15:0]     cmd_addr,
  input  logic [7:0]      cmd_len,
  input  logic [7:0]      cmd_wdata,
  output logic            rsp_valid,
  output logic [7:0]      rsp_data,
  output logic            rsp_last,
  output logic            done,
  output logic            busy,
  input  logic            aec,
  input  logic            rdy,
  output tri logic [15:0] address_7501,
  output tri logic        r_w_7501,
  inout  tri logic [7:0]  data_7501
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [15:0] cur_addr_q, cur_addr_d;
  logic [7:0]  remaining_q, remaining_d;
  logic        is_write_q, is_write_d;
  logic [7:0]  wbyte_q, wbyte_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        rsp_last_q, rsp_last_d;
  logic        done_q, done_d;
  logic        beat_done;

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state_q     <= IDLE;
      cur_addr_q  <= 16'h0000;
      remaining_q <= 8'h00;
      is_write_q  <= 1'b0;
      wbyte_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      is_write_q  <= is_write_d;
      wbyte_q     <= wbyte_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      done_q      <= done_d;
    end
  end

  // Writes ignore RDY like a real 7501; an AEC-low cycle stalls every beat.
  assign beat_done = (state_q == RUN) && aec && (is_write_q || rdy);

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    is_write_d  = is_write_q;
    wbyte_d     = wbyte_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          is_write_d  = ~cmd_rw;
          wbyte_d     = cmd_wdata;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (beat_done) begin
          if (!is_write_q) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = data_7501;
            rsp_last_d  = (remaining_q == 8'h00);
          end
          // The last beat leaves cur_addr on its own address for the idle dummy reads.
          if (remaining_q == 8'h00) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cur_addr_d  = cur_addr_q + 16'h0001;
            remaining_d = remaining_q - 8'h01;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign done      = done_q;

  assign address_7501 = aec ? cur_addr_q : 16'hzzzz;
  assign r_w_7501     = aec ? ((state_q == RUN) ? ~is_write_q : 1'b1) : 1'bz;
  assign data_7501    = (aec && (state_q == RUN) && is_write_q) ? wbyte_q : 8'hzz;

endmodule

// File: tb/tb_bus_master_7501.sv
// Bench for bus_master_7501: directed scenarios plus random traffic, checked each
// cycle against a beat-queue model of the socket bus.
module tb_bus_master_7501;

  logic        clock = 1'b0;
  logic        _reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        done;
  logic        busy;
  logic        aec;
  logic        rdy;
  wire  [15:0] address_7501;
  wire         r_w_7501;
  wire  [7:0]  data_7501;

  int checks = 0;
  int errors = 0;

  // Weak pulls make a released pin observable: address/data float high, R/W floats low.
  for (genvar i = 0; i < 16; i++) begin : g_pu_addr
    pullup (address_7501[i]);
  end
  for (genvar i = 0; i < 8; i++) begin : g_pu_data
    pullup (data_7501[i]);
  end
  pulldown (r_w_7501);

  // Reference model: the list of bus addresses still to be completed for the current command.
  logic [15:0] beat_q[$];
  logic        m_write       = 1'b0;
  logic [7:0]  m_wbyte       = 8'h00;
  logic [15:0] m_idle_addr   = 16'h0000;
  logic        exp_rsp_valid = 1'b0;
  logic [7:0]  exp_rsp_data  = 8'h00;
  logic        exp_rsp_last  = 1'b0;
  logic        exp_done      = 1'b0;
  logic        exp_read_dir  = 1'b1;

  logic [7:0]  tb_rdata  = 8'h3C;
  logic        pin_rdata = 1'b0;
  logic        tb_drv;

  int rsp_cnt  = 0;
  int last_cnt = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  assign tb_drv    = aec && exp_read_dir;
  assign data_7501 = tb_drv ? tb_rdata : 8'hzz;

  bus_master_7501 dut (
    .clock        (clock),
    ._reset       (_reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_last     (rsp_last),
    .done         (done),
    .busy         (busy),
    .aec          (aec),
    .rdy          (rdy),
    .address_7501 (address_7501),
    .r_w_7501     (r_w_7501),
    .data_7501    (data_7501)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to 2ns after the next rising edge and refresh the target's read data.
  task automatic applyStimulus();
    @(posedge clock);
    #2;
    if (!pin_rdata) tb_rdata = 8'($urandom);
  endtask

  task automatic issue(input logic rw, input logic [15:0] addr, input logic [7:0] len, input logic [7:0] wd);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_wdata = wd;
  endtask

  task automatic clear_counts();
    rsp_cnt  = 0;
    last_cnt = 0;
    done_cnt = 0;
    busy_cnt = 0;
  endtask

  // Model update at each edge, then a full output comparison 4ns later.
  always @(posedge clock) begin
    logic        b_e;
    logic [15:0] a_e;
    logic [7:0]  d_e;
    if (!_reset) begin
      beat_q.delete();
      m_write       = 1'b0;
      m_wbyte       = 8'h00;
      m_idle_addr   = 16'h0000;
      exp_rsp_valid = 1'b0;
      exp_rsp_data  = 8'h00;
      exp_rsp_last  = 1'b0;
      exp_done      = 1'b0;
    end else begin
      exp_rsp_valid = 1'b0;
      exp_rsp_last  = 1'b0;
      exp_done      = 1'b0;
      if (beat_q.size() != 0) begin
        if (aec && (m_write || rdy)) begin
          if (!m_write) begin
            exp_rsp_valid = 1'b1;
            exp_rsp_data  = tb_rdata;
            exp_rsp_last  = (beat_q.size() == 1);
          end
          if (beat_q.size() == 1) begin
            exp_done    = 1'b1;
            m_idle_addr = beat_q[0];
          end
          void'(beat_q.pop_front());
        end
      end else if (cmd_valid) begin
        for (int i = 0; i <= int'(cmd_len); i++) beat_q.push_back(cmd_addr + 16'(i));
        m_write = ~cmd_rw;
        m_wbyte = cmd_wdata;
      end
    end
    exp_read_dir = (beat_q.size() == 0) || !m_write;
    #4;
    if (_reset) begin
      b_e = (beat_q.size() != 0);
      a_e = b_e ? beat_q[0] : m_idle_addr;
      d_e = !aec ? 8'hFF : (b_e && m_write) ? m_wbyte : tb_rdata;
      checkOutput("busy", 16'(busy), 16'(b_e));
      checkOutput("cmd_ready", 16'(cmd_ready), 16'(!b_e));
      checkOutput("address", address_7501, aec ? a_e : 16'hFFFF);
      checkOutput("r_w", 16'(r_w_7501), aec ? 16'(b_e ? !m_write : 1'b1) : 16'h0);
      checkOutput("data", 16'(data_7501), 16'(d_e));
      checkOutput("rsp_valid", 16'(rsp_valid), 16'(exp_rsp_valid));
      checkOutput("done", 16'(done), 16'(exp_done));
      if (exp_rsp_valid) begin
        checkOutput("rsp_data", 16'(rsp_data), 16'(exp_rsp_data));
        checkOutput("rsp_last", 16'(rsp_last), 16'(exp_rsp_last));
      end
    end
  end

  always @(negedge clock) begin
    if (_reset) begin
      if (rsp_valid) rsp_cnt++;
      if (rsp_valid && rsp_last) last_cnt++;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
  end

  initial begin
    _reset    = 1'b0;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b1;
    cmd_addr  = 16'h0000;
    cmd_len   = 8'h00;
    cmd_wdata = 8'h00;
    aec       = 1'b1;
    rdy       = 1'b1;
    #12;
    checkOutput("reset cmd_ready", 16'(cmd_ready), 16'h1);
    checkOutput("reset busy", 16'(busy), 16'h0);
    checkOutput("reset rsp_valid", 16'(rsp_valid), 16'h0);
    checkOutput("reset rsp_data", 16'(rsp_data), 16'h00);
    checkOutput("reset rsp_last", 16'(rsp_last), 16'h0);
    checkOutput("reset done", 16'(done), 16'h0);
    checkOutput("reset r_w", 16'(r_w_7501), 16'h1);
    checkOutput("reset address", address_7501, 16'h0000);
    _reset = 1'b1;
    applyStimulus();

    // Single read of 1234 returning A5
    pin_rdata = 1'b1;
    tb_rdata  = 8'hA5;
    issue(1'b1, 16'h1234, 8'd0, 8'h00);
    applyStimulus();
    cmd_valid = 1'b0;
    #2;
    checkOutput("rd1 address", address_7501, 16'h1234);
    checkOutput("rd1 r_w", 16'(r_w_7501), 16'h1);
    checkOutput("rd1 busy", 16'(busy), 16'h1);
    applyStimulus();
    #2;
    checkOutput("rd1 rsp_valid", 16'(rsp_valid), 16'h1);
    checkOutput("rd1 rsp_data", 16'(rsp_data), 16'h00A5);
    checkOutput("rd1 rsp_last", 16'(rsp_last), 16'h1);
    checkOutput("rd1 done", 16'(done), 16'h1);
    checkOutput("rd1 busy after", 16'(busy), 16'h0);
    pin_rdata = 1'b0;
    applyStimulus();

    // Write burst wrapping through FFFF
    begin
      logic [15:0] wr_addrs [3];
      wr_addrs = '{16'hFFFE, 16'hFFFF, 16'h0000};
      issue(1'b0, 16'hFFFE, 8'd2, 8'h00);
      applyStimulus();
      cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
        #2;
        checkOutput("wrap address", address_7501, wr_addrs[i]);
        checkOutput("wrap r_w", 16'(r_w_7501), 16'h0);
        checkOutput("wrap data", 16'(data_7501), 16'h0000);
        applyStimulus();
      end
      #2;
      checkOutput("wrap done", 16'(done), 16'h1);
      checkOutput("wrap r_w idle", 16'(r_w_7501), 16'h1);
      applyStimulus();
    end

    // 4-beat read with AEC low for two cycles on beat 1
    clear_counts();
    issue(1'b1, 16'h0100, 8'd3, 8'h00);
    applyStimulus();
    cmd_valid = 1'b0;
    applyStimulus();
    aec = 1'b0;
    #2;
    checkOutput("aec address z", address_7501, 16'hFFFF);
    checkOutput("aec r_w z", 16'(r_w_7501), 16'h0);
    checkOutput("aec data z", 16'(data_7501), 16'h00FF);
    applyStimulus();
    applyStimulus();
    aec = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("aec rsp count", 16'(rsp_cnt), 16'd4);
    checkOutput("aec last count", 16'(last_cnt), 16'd1);
    checkOutput("aec busy cycles", 16'(busy_cnt), 16'd6);

    // Writes ignore RDY low
    clear_counts();
    rdy = 1'b0;
    issue(1'b0, 16'h2000, 8'd2, 8'h6B);
    applyStimulus();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus();
    checkOutput("wr rdy busy cycles", 16'(busy_cnt), 16'd3);
    checkOutput("wr rdy done count", 16'(done_cnt), 16'd1);

    // Read stretched by three RDY-low cycles
    clear_counts();
    issue(1'b1, 16'h3000, 8'd0, 8'h00);
    applyStimulus();
    cmd_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    applyStimulus();
    rdy = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("rdy busy cycles", 16'(busy_cnt), 16'd4);
    checkOutput("rdy rsp count", 16'(rsp_cnt), 16'd1);

    // Asynchronous reset during beat 2 of an 8-beat write
    issue(1'b0, 16'h4000, 8'd7, 8'h5A);
    applyStimulus();
    cmd_valid = 1'b0;
    applyStimulus();
    applyStimulus();
    #2;
    checkOutput("pre-reset data", 16'(data_7501), 16'h005A);
    _reset = 1'b0;
    #1;
    checkOutput("async reset r_w", 16'(r_w_7501), 16'h1);
    checkOutput("async reset data", 16'(data_7501), 16'h00FF);
    checkOutput("async reset busy", 16'(busy), 16'h0);
    clear_counts();
    applyStimulus();
    _reset = 1'b1;
    applyStimulus();
    applyStimulus();
    #2;
    checkOutput("post-reset cmd_ready", 16'(cmd_ready), 16'h1);
    checkOutput("post-reset address", address_7501, 16'h0000);
    checkOutput("post-reset done count", 16'(done_cnt), 16'd0);
    applyStimulus();

    // Back-to-back commands with cmd_valid held high
    clear_counts();
    issue(1'b0, 16'h5000, 8'd1, 8'h11);
    applyStimulus();
    issue(1'b1, 16'h6000, 8'd0, 8'h00);
    applyStimulus();
    applyStimulus();
    #2;
    checkOutput("b2b idle busy", 16'(busy), 16'h0);
    checkOutput("b2b idle r_w", 16'(r_w_7501), 16'h1);
    checkOutput("b2b idle address", address_7501, 16'h5001);
    applyStimulus();
    cmd_valid = 1'b0;
    #2;
    checkOutput("b2b second busy", 16'(busy), 16'h1);
    checkOutput("b2b second address", address_7501, 16'h6000);
    applyStimulus();
    applyStimulus();
    checkOutput("b2b busy cycles", 16'(busy_cnt), 16'd3);
    checkOutput("b2b done count", 16'(done_cnt), 16'd2);
    checkOutput("b2b rsp count", 16'(rsp_cnt), 16'd1);

    // Random traffic, judged by the per-cycle model comparison
    for (int n = 0; n < 500; n++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_rw    = 1'($urandom);
      cmd_addr  = ($urandom_range(0, 1) != 0) ? (16'hFFF8 + 16'($urandom_range(0, 7))) : 16'($urandom);
      cmd_len   = 8'($urandom_range(0, 6));
      cmd_wdata = 8'($urandom);
      aec       = ($urandom_range(0, 4) != 0);
      rdy       = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end
    cmd_valid = 1'b0;
    aec       = 1'b1;
    rdy       = 1'b1;
    for (int i = 0; i < 12; i++) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
